// File: rtl/rv_mem_resp.sv
// Multicycle memory responder: services fetch/load/store requests against a word array
// with optional wait states. Wait states are compiled in only when RV_MEM_WAIT_EN is defined.
module rv_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        memrw_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        memrw_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        fault;
  logic [IdxW-1:0] idx;
  logic [31:0] mem_q [DEPTH_WORDS];

`ifdef RV_MEM_WAIT_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  // Upper address bits only matter for the range check, never for indexing.
  assign fault = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH_WORDS));
  assign idx   = addr_q[IdxW+1:2];

  always_comb begin
    state_d = state_q;
`ifdef RV_MEM_WAIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
`ifdef RV_MEM_WAIT_EN
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef RV_MEM_WAIT_EN
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      memrw_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
`ifdef RV_MEM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef RV_MEM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
      if (state_q == IDLE && req_i) begin
        memrw_q <= memrw_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      if (state_q == RESP && !memrw_q) rdata_q <= rdata_o;
    end
  end

  // Storage has no reset; a reset before the RESP edge leaves state_q in IDLE so nothing commits.
  always_ff @(posedge clk_i) begin
    if (state_q == RESP && memrw_q && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign ack_o  = (state_q == RESP);
  assign busy_o = (state_q != IDLE);
  assign err_o  = ack_o && fault;

  always_comb begin
    rdata_o = rdata_q;
    if (ack_o && !memrw_q) rdata_o = fault ? 32'h0 : mem_q[idx];
  end

endmodule

// File: doc/rv_mem_resp.md
# rv_mem_resp

Memory responder for the multicycle RISC-V core: the slave end of the control plane's memory request interface. It services instruction-fetch reads, load reads and store writes against an internal word-addressed storage array. It inserts a configurable number of wait states and signals completion with a one-cycle acknowledge. It sits between the control plane/datapath and the storage, in place of the zero-latency memory model, so the controller FSM can be exercised against realistic access latency.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words in storage; power of two, 16..65536
- WAIT_CYCLES, 2, wait states inserted per access; legal range 0..15
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- req  in  1  request valid; sampled only in IDLE
- memrw  in  1  access type: 0 = read, 1 = write (same encoding the control plane drives)
- addr  in  32  byte address; word index = addr[31:2]
- wdata  in  32  store data
- be  in  4  byte enables for writes; be[i] covers wdata[8i+7:8i]; ignored for reads
- ack  out  1  one-cycle completion pulse
- rdata  out  32  read data; valid when ack is high for a read, then held until the next read ack
- busy  out  1  high from the cycle after a request is accepted through the ack cycle
- err  out  1  error flag; pulses with ack for a faulting access

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - When req=1: latch addr, memrw, wdata and be; load the wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
  - When req=0: stay in IDLE.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to RESP in the cycle the counter reaches 1 → 0.
  - req is ignored.
- **RESP**
  - ack=1 for exactly one cycle; return to IDLE.
  - Read: rdata takes the storage word.
  - Write: each byte with be[i]=1 is updated; the other bytes keep their value.
- **Fault check** (latched address):
  - A fault is addr[1:0]≠0 or addr[31:2] ≥ DEPTH_WORDS.
  - On a fault: err=1 with ack, storage is unmodified, and a faulting read drives rdata=0.
- Requests are not queued. req held high across RESP is taken as a new request in the following IDLE cycle. The control plane must drop req in the cycle after it sees ack unless it issues a new access.
- Width rules:
  - Word index is addr[$clog2(DEPTH_WORDS)+1:2] after the range check.
  - Address bits above that range only participate in the range check.

## Timing
- Reset values (rst=0, asynchronous):
  - State IDLE, counter 0.
  - ack=0, busy=0, err=0, rdata=0.
  - Storage contents are not reset and are preserved across reset.
- Latency:
  - A req sampled at rising edge N gives ack high during cycle N+1+WAIT_CYCLES.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- Writes commit at the rising edge that ends the RESP cycle.
- A read in the cycle directly after a write ack to the same word returns the new data.
- Reset during WAIT or RESP (before that edge) abandons the access: no write commits and no ack is generated.
- busy and ack are never both low while the FSM is outside IDLE. ack implies busy.

## Configuration
- RV_MEM_WAIT_EN
  - **Defined:** WAIT state and counter are compiled in; latency follows WAIT_CYCLES.
  - **Undefined:** WAIT state and counter are removed; WAIT_CYCLES is ignored; every access completes IDLE→RESP with ack in cycle N+1.

## Test plan
- **Reset:** rst=0 mid-WAIT of a write to 0x10 → ack/busy/err/rdata=0 immediately; the next read of 0x10 returns the prior contents.
- **Write then read, WAIT_CYCLES=2:** write wdata=0xDEADBEEF, be=4'hF to addr 0x40 at edge 0, then read 0x40 → first ack in cycle 3, second read ack 4 cycles later with rdata=0xDEADBEEF, err=0.
- **Byte enables:** word 0x40=0xDEADBEEF, then write wdata=0x11223344 with be=4'b0101 → read returns 0xDE22BE44.
- **Faults:** read at 0x41 → ack with err=1, rdata=0. Write at 4*DEPTH_WORDS → err=1, and a readback of word 0 is unchanged.
- **Back-to-back:** req held high continuously for 3 reads → exactly 3 ack pulses spaced WAIT_CYCLES+2 apart; busy drops for one IDLE cycle between them.
- **Macro off:** rebuild without RV_MEM_WAIT_EN and WAIT_CYCLES=5 → every ack arrives in cycle N+1.
